aes_stream_adapter: RTL and testbench

Word-serial front/back end for the AES cipher core. Assembles a 128-bit key and a 128-bit plaintext block from a 32-bit valid/ready input stream and pulses the core's `ld`. It captures `text_out` on `done` and returns the ciphertext as four 32-bit words on a valid/ready output stream. It sits directly upstream and downstream of `aes_cipher_top` and drives that core's `ld`, `key` and `text_in`.

---
 rtl/aes_stream_pkg.sv | 20 ++
 rtl/aes_word_shifter.sv | 44 ++++
 rtl/aes_stream_adapter.sv | 189 ++++++++++++++++++
 tb/tb_aes_stream_adapter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_stream_pkg.sv
// aes_stream_pkg: shared types and widths for the AES word-serial stream adapter.
// Revision 1.0
`default_nettype none

package aes_stream_pkg;

    localparam int AES_WORD_W = 32;
    localparam int AES_BLK_W  = 128;
    localparam int AES_WORDS  = 4;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } aes_stream_state_t;

endpackage

`default_nettype wire

// File: rtl/aes_word_shifter.sv
// aes_word_shifter: 128-bit register with parallel load, 32-bit shift-in at the LSW and an MSW tap.
// Revision 1.0
`default_nettype none

module aes_word_shifter
    import aes_stream_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic [AES_BLK_W-1:0]  load_data_i,
    input  logic                  shift_i,
    input  logic [AES_WORD_W-1:0] shift_data_i,
    output logic [AES_BLK_W-1:0]  q_o,
    output logic [AES_WORD_W-1:0] msw_o
);

    logic [AES_BLK_W-1:0] data_q;
    logic [AES_BLK_W-1:0] data_d;

    // Parallel load wins over a shift in the same cycle.
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_data_i;
        end else if (shift_i) begin
            data_d = {data_q[AES_BLK_W-AES_WORD_W-1:0], shift_data_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o   = data_q;
    assign msw_o = data_q[AES_BLK_W-1 -: AES_WORD_W];

endmodule

`default_nettype wire

// File: rtl/aes_stream_adapter.sv
// aes_stream_adapter: assembles key/text from a 32-bit stream, drives the AES core, streams the result back.
// Revision 1.0
`default_nettype none

module aes_stream_adapter
    import aes_stream_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AES_WORD_W-1:0] in_data,
    input  logic                  in_is_key,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [AES_WORD_W-1:0] out_data,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  core_ld,
    output logic [AES_BLK_W-1:0]  core_key,
    output logic [AES_BLK_W-1:0]  core_text,
    input  logic                  core_done,
    input  logic [AES_BLK_W-1:0]  core_result,
    output logic                  busy,
    output logic                  err_nokey,
    output logic                  err_timeout
);

    localparam int                WCNT_W    = $clog2(TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    aes_stream_state_t state_q, state_d;
    logic [1:0]        kcnt_q, kcnt_d;
    logic [1:0]        tcnt_q, tcnt_d;
    logic [1:0]        ocnt_q, ocnt_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              key_ok_q, key_ok_d;
    logic              err_nokey_q, err_nokey_d;
    logic              err_timeout_q, err_timeout_d;
    logic [AES_BLK_W-1:0] key_reg_q, key_reg_d;

    logic                  key_shift, txt_shift, out_load, out_shift;
    logic [AES_BLK_W-1:0]  key_stage_q, txt_reg_q, out_sr_q;
    logic [AES_WORD_W-1:0] key_stage_msw, txt_msw;

    // Words are only accepted in LOAD, so shifting is gated by state alone.
    assign key_shift = (state_q == S_LOAD) & in_valid &  in_is_key;
    assign txt_shift = (state_q == S_LOAD) & in_valid & ~in_is_key;

    aes_word_shifter u_key_stage (
        .clk          (clk),
        .reset        (reset),
        .load_i       (1'b0),
        .load_data_i  ('0),
        .shift_i      (key_shift),
        .shift_data_i (in_data),
        .q_o          (key_stage_q),
        .msw_o        (key_stage_msw)
    );

    aes_word_shifter u_txt_reg (
        .clk          (clk),
        .reset        (reset),
        .load_i       (1'b0),
        .load_data_i  ('0),
        .shift_i      (txt_shift),
        .shift_data_i (in_data),
        .q_o          (txt_reg_q),
        .msw_o        (txt_msw)
    );

    aes_word_shifter u_out_sr (
        .clk          (clk),
        .reset        (reset),
        .load_i       (out_load),
        .load_data_i  (core_result),
        .shift_i      (out_shift),
        .shift_data_i ('0),
        .q_o          (out_sr_q),
        .msw_o        (out_data)
    );

    logic unused_taps;
    assign unused_taps = ^{key_stage_msw, key_stage_q[AES_BLK_W-1 -: AES_WORD_W], txt_msw, out_sr_q};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_LOAD;
            kcnt_q        <= '0;
            tcnt_q        <= '0;
            ocnt_q        <= '0;
            wcnt_q        <= '0;
            key_ok_q      <= 1'b0;
            err_nokey_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            key_reg_q     <= '0;
        end else begin
            state_q       <= state_d;
            kcnt_q        <= kcnt_d;
            tcnt_q        <= tcnt_d;
            ocnt_q        <= ocnt_d;
            wcnt_q        <= wcnt_d;
            key_ok_q      <= key_ok_d;
            err_nokey_q   <= err_nokey_d;
            err_timeout_q <= err_timeout_d;
            key_reg_q     <= key_reg_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        kcnt_d        = kcnt_q;
        tcnt_d        = tcnt_q;
        ocnt_d        = ocnt_q;
        wcnt_d        = wcnt_q;
        key_ok_d      = key_ok_q;
        err_nokey_d   = err_nokey_q;
        err_timeout_d = err_timeout_q;
        key_reg_d     = key_reg_q;
        in_ready      = 1'b0;
        core_ld       = 1'b0;
        out_valid     = 1'b0;
        out_last      = 1'b0;
        out_load      = 1'b0;
        out_shift     = 1'b0;

        case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && in_is_key) begin
                    kcnt_d = kcnt_q + 2'd1;
                    // Only a completed key reaches the core; include the word arriving now.
                    if (kcnt_q == 2'd3) begin
                        key_reg_d = {key_stage_q[AES_BLK_W-AES_WORD_W-1:0], in_data};
                        key_ok_d  = 1'b1;
                    end
                end else if (in_valid) begin
                    tcnt_d = tcnt_q + 2'd1;
                    if (tcnt_q == 2'd3) begin
                        if (key_ok_q) begin
                            state_d = S_START;
                        end else begin
                            err_nokey_d = 1'b1;
                        end
                    end
                end
            end
            S_START: begin
                core_ld = 1'b1;
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wcnt_d = wcnt_q + 1'b1;
                if (core_done) begin
                    out_load = 1'b1;
                    state_d  = S_DRAIN;
                end else if (wcnt_q == WCNT_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_LOAD;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                out_last  = (ocnt_q == 2'd3);
                if (out_ready) begin
                    out_shift = 1'b1;
                    ocnt_d    = ocnt_q + 2'd1;
                    if (ocnt_q == 2'd3) begin
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    assign busy        = (state_q != S_LOAD);
    assign core_key    = key_reg_q;
    assign core_text   = txt_reg_q;
    assign err_nokey   = err_nokey_q;
    assign err_timeout = err_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_stream_adapter.sv
// tb_aes_stream_adapter: directed + randomized checks of the adapter against a stub XOR core and a word-level model.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_aes_stream_adapter;

    localparam int TIMEOUT  = 64;
    localparam int DONE_LAT = 11;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_is_key = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         core_ld;
    logic [127:0] core_key;
    logic [127:0] core_text;
    logic         core_done;
    logic [127:0] core_result;
    logic         busy;
    logic         err_nokey;
    logic         err_timeout;

    always #5 clk = ~clk;

    aes_stream_adapter #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_is_key   (in_is_key),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .core_ld     (core_ld),
        .core_key    (core_key),
        .core_text   (core_text),
        .core_done   (core_done),
        .core_result (core_result),
        .busy        (busy),
        .err_nokey   (err_nokey),
        .err_timeout (err_timeout)
    );

    // Stub core: result = text ^ key, done pulses DONE_LAT cycles after ld.
    logic stub_en = 1'b1;
    int   ld_age = 0;
    int   ld_count = 0;
    always @(posedge clk) begin
        if (core_ld) begin
            ld_age   <= 1;
            ld_count <= ld_count + 1;
        end else if (ld_age != 0 && ld_age < DONE_LAT) begin
            ld_age <= ld_age + 1;
        end else begin
            ld_age <= 0;
        end
    end
    assign core_done   = stub_en && (ld_age == DONE_LAT);
    assign core_result = core_text ^ core_key;

    // Word-level reference model.
    logic [127:0] m_key = '0;
    logic         m_key_ok = 1'b0;
    logic         m_nokey = 1'b0;
    logic         m_timeout = 1'b0;
    logic [31:0]  m_kw[$];
    logic [31:0]  m_tw[$];
    logic [31:0]  exp_q[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_key = '0; m_key_ok = 1'b0; m_nokey = 1'b0; m_timeout = 1'b0;
        m_kw.delete(); m_tw.delete(); exp_q.delete();
    endtask

    task automatic model_word(input logic [31:0] d, input logic k);
        logic [127:0] blk;
        if (k) begin
            m_kw.push_back(d);
            if (m_kw.size() == 4) begin
                m_key = {m_kw[0], m_kw[1], m_kw[2], m_kw[3]};
                m_key_ok = 1'b1;
                m_kw.delete();
            end
        end else begin
            m_tw.push_back(d);
            if (m_tw.size() == 4) begin
                blk = {m_tw[0], m_tw[1], m_tw[2], m_tw[3]};
                m_tw.delete();
                if (m_key_ok) begin
                    blk = blk ^ m_key;
                    for (int i = 0; i < 4; i++) exp_q.push_back(blk[127-32*i -: 32]);
                end else begin
                    m_nokey = 1'b1;
                end
            end
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic k);
        int guard;
        guard = 0;
        @(negedge clk);
        in_data = d; in_is_key = k; in_valid = 1'b1;
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", in_ready, 1'b1);
        @(posedge clk);
        model_word(d, k);
        #1 in_valid = 1'b0;
    endtask

    // Call right after the 4th text word: START cycle must carry the single ld pulse.
    task automatic check_ld_pulse();
        @(negedge clk);
        check("ld_start", core_ld, 1'b1);
        check("in_ready_start", in_ready, 1'b0);
        @(negedge clk);
        check("ld_one_cycle", core_ld, 1'b0);
        check("busy_wait", busy, 1'b1);
    endtask

    // mode 0: ready high, 1: ready pattern 1-0-0-1, 2: random ready
    task automatic collect_block(input int mode);
        int got, cyc, p;
        logic r;
        logic [0:3] pat;
        got = 0; cyc = 0; p = 0; pat = 4'b1001;
        while (got < 4 && cyc < 300) begin
            @(negedge clk);
            if (out_valid) begin
                check("out_data", out_data, exp_q.size() != 0 ? exp_q[0] : 32'hxxxxxxxx);
                check("out_last", out_last, (got == 3));
                r = (mode == 0) ? 1'b1 : (mode == 1) ? pat[p % 4] : 1'($urandom_range(0, 1));
                out_ready = r;
                p++;
                if (r) begin
                    void'(exp_q.pop_front());
                    got++;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            cyc++;
        end
        check("block_words", got, 4);
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_done_valid", out_valid, 1'b0);
        check("drain_done_ready", in_ready, 1'b1);
    endtask

    logic [31:0] kw1[4] = '{32'hcafebabe, 32'hdeadbeef, 32'hdeadbeef, 32'h00000000};
    logic [31:0] tw1[4] = '{32'hbba47f76, 32'h875f634a, 32'h85d6fe52, 32'h004297b4};
    logic [31:0] ow1[4] = '{32'h715ac5c8, 32'h59f2dda5, 32'h5b7b40bd, 32'h004297b4};

    initial begin
        int ld0;
        logic seen_valid;
        logic [31:0] words[$];
        logic        kinds[$];

        // Reset values
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_core_ld", core_ld, 1'b0);
        check("rst_core_key", core_key, 128'h0);
        check("rst_core_text", core_text, 128'h0);
        check("rst_err", {err_nokey, err_timeout}, 2'b00);

        // Text block without any key
        ld0 = ld_count;
        for (int i = 0; i < 4; i++) send_word(tw1[i], 1'b0);
        @(negedge clk);
        check("nokey_flag", err_nokey, m_nokey);
        check("nokey_flag_set", err_nokey, 1'b1);
        check("nokey_no_ld", ld_count - ld0, 0);
        check("nokey_in_ready", in_ready, 1'b1);

        // Key then text, published vector
        ld0 = ld_count;
        for (int i = 0; i < 4; i++) send_word(kw1[i], 1'b1);
        for (int i = 0; i < 4; i++) send_word(tw1[i], 1'b0);
        for (int i = 0; i < 4; i++) check("vec1_model", exp_q[i], ow1[i]);
        check_ld_pulse();
        collect_block(0);
        check("vec1_ld_count", ld_count - ld0, 1);

        // Key reuse with zero text
        for (int i = 0; i < 4; i++) send_word(32'h0, 1'b0);
        check_ld_pulse();
        collect_block(0);

        // Interleaved K,T,K,T,...
        ld0 = ld_count;
        for (int i = 0; i < 4; i++) begin
            send_word(kw1[i], 1'b1);
            send_word(tw1[i], 1'b0);
        end
        check_ld_pulse();
        collect_block(0);
        check("ilv_ld_count", ld_count - ld0, 1);

        // Output stall pattern 1-0-0-1
        for (int i = 0; i < 4; i++) send_word($urandom, 1'b0);
        check_ld_pulse();
        collect_block(1);

        // Randomized blocks: random key words (none / partial / full) shuffled with 3 text words
        for (int b = 0; b < 8; b++) begin
            int nk, j;
            logic [31:0] tw;
            logic        tk;
            nk = ($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 3) == 0) ? 2 : 4);
            words.delete(); kinds.delete();
            for (int i = 0; i < nk; i++) begin words.push_back($urandom); kinds.push_back(1'b1); end
            for (int i = 0; i < 3; i++) begin words.push_back($urandom); kinds.push_back(1'b0); end
            for (int i = words.size() - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                tw = words[i]; words[i] = words[j]; words[j] = tw;
                tk = kinds[i]; kinds[i] = kinds[j]; kinds[j] = tk;
            end
            ld0 = ld_count;
            for (int i = 0; i < words.size(); i++) send_word(words[i], kinds[i]);
            send_word($urandom, 1'b0);
            check_ld_pulse();
            collect_block(2);
            check("rnd_ld_count", ld_count - ld0, 1);
            check("rnd_core_key", core_key, m_key);
        end

        // Core never answers: timeout after exactly TIMEOUT WAIT cycles
        stub_en = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 4; i++) send_word($urandom, 1'b0);
        @(negedge clk);
        check("to_ld", core_ld, 1'b1);
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("to_not_yet", err_timeout, 1'b0);
        check("to_busy_before", busy, 1'b1);
        @(negedge clk);
        m_timeout = 1'b1;
        exp_q.delete();
        check("to_flag", err_timeout, m_timeout);
        check("to_back_load", busy, 1'b0);
        check("to_in_ready", in_ready, 1'b1);
        check("to_no_output", seen_valid, 1'b0);
        stub_en = 1'b1;

        // Reset during WAIT
        for (int i = 0; i < 4; i++) send_word($urandom, 1'b0);
        check_ld_pulse();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        model_reset();
        check("mr_core_ld", core_ld, 1'b0);
        check("mr_out_valid", out_valid, 1'b0);
        check("mr_out_last", out_last, 1'b0);
        check("mr_busy", busy, 1'b0);
        check("mr_in_ready", in_ready, 1'b1);
        check("mr_errs", {err_nokey, err_timeout}, {m_nokey, m_timeout});
        check("mr_core_key", core_key, m_key);
        check("mr_core_text", core_text, 128'h0);
        check("mr_out_data", out_data, 32'h0);
        reset = 1'b1;

        // Key was discarded by reset
        ld0 = ld_count;
        for (int i = 0; i < 4; i++) send_word($urandom, 1'b0);
        repeat (20) @(negedge clk);
        check("mr_nokey", err_nokey, m_nokey);
        check("mr_no_ld", ld_count - ld0, 0);
        check("mr_quiet", out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
